// File: rtl/pipe_ctrl_pkg.sv
// Shared field layout for the FETCH->EXEC->MEM->WB control registers.
// A bubble is the all-zero word in every layout below.
package pipe_ctrl_pkg;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_INSTRET_W  = 32;

    // Early stages (FETCH, EXEC) carry {rs2, rs1, rd, mem2reg, reg_write, valid}.
    localparam int VALID_BIT = 0;
    localparam int RW_BIT    = 1;
    localparam int M2R_BIT   = 2;
    localparam int CTL_BITS  = 3;

    // Late stages (MEM, WB) only need {rd, reg_write, valid}.
    localparam int LATE_RD_LSB = 2;

    function automatic int pipe_ctl_w(input int aw);
        return CTL_BITS + 3 * aw;
    endfunction

    function automatic int late_ctl_w(input int aw);
        return LATE_RD_LSB + aw;
    endfunction

endpackage

// File: rtl/pipe_ctrl_pipe_reg.sv
// One pipeline control register: flush beats stall beats load.
// Reset and flush both leave a bubble (all zeros).
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Per-stage control state for the 4-stage pipeline, driven by the Hazard unit's
// stall/flush requests; reports back the fields Hazard needs and counts retirements.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int INSTRET_W  = DEF_INSTRET_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  IF_valid,
    input  logic [REG_ADDR_W-1:0] IF_rs1,
    input  logic [REG_ADDR_W-1:0] IF_rs2,
    input  logic [REG_ADDR_W-1:0] IF_rd,
    input  logic                  IF_reg_write,
    input  logic                  IF_mem2reg,
    input  logic                  FETCH_stall,
    input  logic                  EXEC_stall,
    input  logic                  EXEC_flush,
    input  logic                  MEM_flush,
    output logic                  FETCH_valid,
    output logic [REG_ADDR_W-1:0] FETCH_rs1,
    output logic [REG_ADDR_W-1:0] FETCH_rs2,
    output logic [REG_ADDR_W-1:0] EXEC_rs1,
    output logic [REG_ADDR_W-1:0] EXEC_rs2,
    output logic [REG_ADDR_W-1:0] EXEC_rd,
    output logic                  EXEC_mem2reg,
    output logic                  MEM_valid,
    output logic [REG_ADDR_W-1:0] MEM_rd,
    output logic [REG_ADDR_W-1:0] WB_rd,
    output logic                  MEM_rd_reg_write,
    output logic                  WB_rd_reg_write,
    output logic [INSTRET_W-1:0]  instret,
    output logic                  stall_err
);

    localparam int EW      = pipe_ctl_w(REG_ADDR_W);
    localparam int LW      = late_ctl_w(REG_ADDR_W);
    localparam int RD_LSB  = CTL_BITS;
    localparam int RS1_LSB = CTL_BITS + REG_ADDR_W;
    localparam int RS2_LSB = CTL_BITS + 2 * REG_ADDR_W;
    localparam logic [INSTRET_W-1:0] INSTRET_INC = {{(INSTRET_W-1){1'b0}}, 1'b1};

    logic [EW-1:0] fetch_d;
    logic [EW-1:0] fetch_q;
    logic [EW-1:0] exec_q;
    logic [LW-1:0] mem_d;
    logic [LW-1:0] mem_q;
    logic [LW-1:0] wb_q;
    logic          mem_kill;

    // x0 is never a real destination, so its write-enable dies at capture.
    always_comb begin
        fetch_d = '0;
        if (IF_valid) begin
            fetch_d[VALID_BIT]                = 1'b1;
            fetch_d[RW_BIT]                   = IF_reg_write & (IF_rd != '0);
            fetch_d[M2R_BIT]                  = IF_mem2reg;
            fetch_d[RD_LSB  +: REG_ADDR_W]    = IF_rd;
            fetch_d[RS1_LSB +: REG_ADDR_W]    = IF_rs1;
            fetch_d[RS2_LSB +: REG_ADDR_W]    = IF_rs2;
        end
    end

    pipe_reg #(.W(EW)) u_fetch (
        .clk   (clk),
        .rst   (rst),
        .stall (FETCH_stall),
        .flush (1'b0),
        .d     (fetch_d),
        .q     (fetch_q)
    );

    pipe_reg #(.W(EW)) u_exec (
        .clk   (clk),
        .rst   (rst),
        .stall (EXEC_stall),
        .flush (EXEC_flush),
        .d     (fetch_q),
        .q     (exec_q)
    );

    // A held EXEC instr must not also advance, so MEM takes a bubble on EXEC_stall.
    assign mem_kill = MEM_flush | EXEC_stall;
    assign mem_d    = {exec_q[RD_LSB +: REG_ADDR_W], exec_q[RW_BIT], exec_q[VALID_BIT]};

    pipe_reg #(.W(LW)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .stall (1'b0),
        .flush (mem_kill),
        .d     (mem_d),
        .q     (mem_q)
    );

    pipe_reg #(.W(LW)) u_wb (
        .clk   (clk),
        .rst   (rst),
        .stall (1'b0),
        .flush (1'b0),
        .d     (mem_q),
        .q     (wb_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret <= '0;
        end else if (wb_q[VALID_BIT]) begin
            instret <= instret + INSTRET_INC;
        end
    end

    // EXEC holding while FETCH moves on loses an instruction; remember it until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_err <= 1'b0;
        end else if (EXEC_stall && !FETCH_stall) begin
            stall_err <= 1'b1;
        end
    end

    assign FETCH_valid      = fetch_q[VALID_BIT];
    assign FETCH_rs1        = fetch_q[RS1_LSB +: REG_ADDR_W];
    assign FETCH_rs2        = fetch_q[RS2_LSB +: REG_ADDR_W];
    assign EXEC_rs1         = exec_q[RS1_LSB +: REG_ADDR_W];
    assign EXEC_rs2         = exec_q[RS2_LSB +: REG_ADDR_W];
    assign EXEC_rd          = exec_q[RD_LSB +: REG_ADDR_W];
    assign EXEC_mem2reg     = exec_q[VALID_BIT] & exec_q[M2R_BIT];
    assign MEM_valid        = mem_q[VALID_BIT];
    assign MEM_rd           = mem_q[LATE_RD_LSB +: REG_ADDR_W];
    assign MEM_rd_reg_write = mem_q[VALID_BIT] & mem_q[RW_BIT];
    assign WB_rd            = wb_q[LATE_RD_LSB +: REG_ADDR_W];
    assign WB_rd_reg_write  = wb_q[VALID_BIT] & wb_q[RW_BIT];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, straight-line flow, load-use, branch,
// x0 writes, illegal stall, mid-stream reset and instret wrap (INSTRET_W=4).
module tb_pipe_ctrl;

    localparam int AW = 5;
    localparam int IW = 4;

    logic          clk;
    logic          rst;
    logic          IF_valid;
    logic [AW-1:0] IF_rs1;
    logic [AW-1:0] IF_rs2;
    logic [AW-1:0] IF_rd;
    logic          IF_reg_write;
    logic          IF_mem2reg;
    logic          FETCH_stall;
    logic          EXEC_stall;
    logic          EXEC_flush;
    logic          MEM_flush;
    logic          FETCH_valid;
    logic [AW-1:0] FETCH_rs1;
    logic [AW-1:0] FETCH_rs2;
    logic [AW-1:0] EXEC_rs1;
    logic [AW-1:0] EXEC_rs2;
    logic [AW-1:0] EXEC_rd;
    logic          EXEC_mem2reg;
    logic          MEM_valid;
    logic [AW-1:0] MEM_rd;
    logic [AW-1:0] WB_rd;
    logic          MEM_rd_reg_write;
    logic          WB_rd_reg_write;
    logic [IW-1:0] instret;
    logic          stall_err;

    int n_checks = 0;
    int n_pass   = 0;
    logic [AW-1:0] exp_q[$];

    pipe_ctrl #(.REG_ADDR_W(AW), .INSTRET_W(IW)) dut (
        .clk              (clk),
        .rst              (rst),
        .IF_valid         (IF_valid),
        .IF_rs1           (IF_rs1),
        .IF_rs2           (IF_rs2),
        .IF_rd            (IF_rd),
        .IF_reg_write     (IF_reg_write),
        .IF_mem2reg       (IF_mem2reg),
        .FETCH_stall      (FETCH_stall),
        .EXEC_stall       (EXEC_stall),
        .EXEC_flush       (EXEC_flush),
        .MEM_flush        (MEM_flush),
        .FETCH_valid      (FETCH_valid),
        .FETCH_rs1        (FETCH_rs1),
        .FETCH_rs2        (FETCH_rs2),
        .EXEC_rs1         (EXEC_rs1),
        .EXEC_rs2         (EXEC_rs2),
        .EXEC_rd          (EXEC_rd),
        .EXEC_mem2reg     (EXEC_mem2reg),
        .MEM_valid        (MEM_valid),
        .MEM_rd           (MEM_rd),
        .WB_rd            (WB_rd),
        .MEM_rd_reg_write (MEM_rd_reg_write),
        .WB_rd_reg_write  (WB_rd_reg_write),
        .instret          (instret),
        .stall_err        (stall_err)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_if(input logic v, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                            input logic [AW-1:0] rs2, input logic rw, input logic m2r);
        IF_valid     = v;
        IF_rd        = rd;
        IF_rs1       = rs1;
        IF_rs2       = rs2;
        IF_reg_write = rw;
        IF_mem2reg   = m2r;
    endtask

    task automatic drive_hz(input logic fs, input logic es, input logic ef, input logic mf);
        FETCH_stall = fs;
        EXEC_stall  = es;
        EXEC_flush  = ef;
        MEM_flush   = mf;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b0;
        drive_if(1'b0, '0, '0, '0, 1'b0, 1'b0);
        drive_hz(1'b0, 1'b0, 1'b0, 1'b0);

        // Power-on reset
        #1 rst = 1'b1;
        #2;
        check("rst_fetch_valid", 32'(FETCH_valid), 0);
        check("rst_mem_valid",   32'(MEM_valid), 0);
        check("rst_exec_rd",     32'(EXEC_rd), 0);
        check("rst_instret",     32'(instret), 0);
        check("rst_stall_err",   32'(stall_err), 0);
        @(negedge clk) rst = 1'b0;

        // Straight-line: rd=5 flows one stage per cycle
        drive_if(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b0);
        step();
        drive_if(1'b0, '0, '0, '0, 1'b0, 1'b0);
        check("sl_fetch_valid", 32'(FETCH_valid), 1);
        check("sl_fetch_rs1",   32'(FETCH_rs1), 1);
        check("sl_fetch_rs2",   32'(FETCH_rs2), 2);
        step();
        check("sl_exec_rd",  32'(EXEC_rd), 5);
        check("sl_exec_rs1", 32'(EXEC_rs1), 1);
        check("sl_exec_rs2", 32'(EXEC_rs2), 2);
        step();
        check("sl_mem_rd",  32'(MEM_rd), 5);
        check("sl_mem_rw",  32'(MEM_rd_reg_write), 1);
        check("sl_mem_val", 32'(MEM_valid), 1);
        step();
        check("sl_wb_rd",      32'(WB_rd), 5);
        check("sl_wb_rw",      32'(WB_rd_reg_write), 1);
        check("sl_instret_c3", 32'(instret), 0);
        step();
        check("sl_instret_c4", 32'(instret), 1);

        // Load-use: load rd=7 followed by consumer of x7
        drive_if(1'b1, 5'd7, 5'd3, 5'd0, 1'b1, 1'b1);
        step();
        drive_if(1'b1, 5'd8, 5'd7, 5'd4, 1'b1, 1'b0);
        step();
        check("lu_exec_m2r", 32'(EXEC_mem2reg), 1);
        check("lu_exec_rd",  32'(EXEC_rd), 7);
        check("lu_fetch_rs1", 32'(FETCH_rs1), 7);
        drive_if(1'b1, 5'd9, 5'd4, 5'd4, 1'b1, 1'b0);
        drive_hz(1'b1, 1'b0, 1'b1, 1'b0);
        step();
        drive_if(1'b0, '0, '0, '0, 1'b0, 1'b0);
        drive_hz(1'b0, 1'b0, 1'b0, 1'b0);
        check("lu_fetch_hold_v",  32'(FETCH_valid), 1);
        check("lu_fetch_hold_r1", 32'(FETCH_rs1), 7);
        check("lu_fetch_hold_r2", 32'(FETCH_rs2), 4);
        check("lu_exec_bubble",   32'(EXEC_rd), 0);
        check("lu_exec_m2r_0",    32'(EXEC_mem2reg), 0);
        check("lu_mem_load_rd",   32'(MEM_rd), 7);
        check("lu_mem_load_v",    32'(MEM_valid), 1);
        step();
        check("lu_consumer_rd",  32'(EXEC_rd), 8);
        check("lu_consumer_rs1", 32'(EXEC_rs1), 7);
        check("lu_mem_bubble",   32'(MEM_valid), 0);
        check("lu_wb_load",      32'(WB_rd), 7);
        check("lu_fetch_empty",  32'(FETCH_valid), 0);
        step();
        step();
        step();
        check("lu_instret", 32'(instret), 3);

        // Branch: EXEC and MEM flushed together, only the oldest survives
        drive_if(1'b1, 5'd10, 5'd0, 5'd0, 1'b1, 1'b0);
        step();
        drive_if(1'b1, 5'd11, 5'd0, 5'd0, 1'b1, 1'b0);
        step();
        drive_if(1'b1, 5'd12, 5'd0, 5'd0, 1'b1, 1'b0);
        step();
        drive_if(1'b0, '0, '0, '0, 1'b0, 1'b0);
        drive_hz(1'b0, 1'b0, 1'b1, 1'b1);
        step();
        drive_hz(1'b0, 1'b0, 1'b0, 1'b0);
        check("br_exec_bubble", 32'(EXEC_rd), 0);
        check("br_mem_bubble",  32'(MEM_valid), 0);
        check("br_mem_rw",      32'(MEM_rd_reg_write), 0);
        check("br_wb_oldest",   32'(WB_rd), 10);
        step();
        check("br_mem_next", 32'(MEM_valid), 0);
        step();
        step();
        check("br_instret", 32'(instret), 4);

        // x0 destination never raises a writeback
        drive_if(1'b1, 5'd0, 5'd1, 5'd1, 1'b1, 1'b0);
        step();
        drive_if(1'b0, '0, '0, '0, 1'b0, 1'b0);
        check("x0_fetch_valid", 32'(FETCH_valid), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("x0_mem_rw", 32'(MEM_rd_reg_write), 0);
            check("x0_wb_rw",  32'(WB_rd_reg_write), 0);
            if (k == 1) check("x0_mem_valid", 32'(MEM_valid), 1);
        end
        check("x0_instret", 32'(instret), 5);

        // Illegal EXEC_stall without FETCH_stall
        drive_if(1'b1, 5'd13, 5'd0, 5'd0, 1'b1, 1'b0);
        step();
        drive_if(1'b1, 5'd14, 5'd0, 5'd0, 1'b1, 1'b0);
        step();
        check("il_err_before", 32'(stall_err), 0);
        drive_if(1'b1, 5'd15, 5'd6, 5'd0, 1'b1, 1'b0);
        drive_hz(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        drive_if(1'b0, '0, '0, '0, 1'b0, 1'b0);
        drive_hz(1'b0, 1'b0, 1'b0, 1'b0);
        check("il_err_set",    32'(stall_err), 1);
        check("il_exec_hold",  32'(EXEC_rd), 13);
        check("il_fetch_load", 32'(FETCH_rs1), 6);
        check("il_mem_bubble", 32'(MEM_valid), 0);
        step();
        check("il_err_sticky", 32'(stall_err), 1);
        check("il_exec_next",  32'(EXEC_rd), 15);
        check("il_mem_held",   32'(MEM_rd), 13);
        for (int k = 0; k < 4; k++) step();
        check("il_instret",  32'(instret), 7);
        check("il_err_still", 32'(stall_err), 1);

        // Mid-stream async reset with three instrs in flight
        drive_if(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0);
        step();
        drive_if(1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b1);
        step();
        drive_if(1'b1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0);
        step();
        drive_if(1'b0, '0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("mr_fetch_valid", 32'(FETCH_valid), 0);
        check("mr_exec_m2r",    32'(EXEC_mem2reg), 0);
        check("mr_mem_valid",   32'(MEM_valid), 0);
        check("mr_mem_rw",      32'(MEM_rd_reg_write), 0);
        check("mr_wb_rw",       32'(WB_rd_reg_write), 0);
        check("mr_instret",     32'(instret), 0);
        check("mr_stall_err",   32'(stall_err), 0);
        @(negedge clk) rst = 1'b0;

        // 17 back-to-back retirements wrap a 4-bit counter to 1
        for (int c = 0; c <= 20; c++) begin
            if (c < 17) begin
                drive_if(1'b1, AW'(c + 1), 5'd0, 5'd0, 1'b1, 1'b0);
                exp_q.push_back(AW'(c + 1));
            end else begin
                drive_if(1'b0, '0, '0, '0, 1'b0, 1'b0);
            end
            step();
            if (c >= 3 && c < 20) begin
                check("wr_wb_rd", 32'(WB_rd), 32'(exp_q.pop_front()));
                check("wr_wb_rw", 32'(WB_rd_reg_write), 1);
            end
            if (c == 19) check("wr_instret_wrap0", 32'(instret), 0);
        end
        check("wr_instret", 32'(instret), 1);
        check("wr_queue_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
